i2c_reg_writer: RTL and testbench

Single-master I2C write engine that sits directly downstream of the OLED display sequencer. It accepts one register write request at a time as a register address plus a data byte. For each request it emits a complete three-byte I2C write frame: START, device address with W, register address, data, STOP. It pulses `done` when the bus is released. It drives SCL push-pull and SDA open-drain.

---
 rtl/i2c_reg_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_reg_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_writer.sv
// -----------------------------------------------------------------------------
// i2c_reg_writer
// Single-master I2C write engine. Each accepted request becomes one frame on
// the wire: START, {DEV_ADDR,W}, reg_addr, reg_data, STOP. SCL is push-pull,
// SDA is open-drain (sda_oe=1 pulls the line low).
//
// Parameters
//   DEV_ADDR  7-bit slave address (first byte on the wire is {DEV_ADDR,1'b0})
//   CLK_DIV   clk cycles per SCL quarter-period (2..65535)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   write_en   in   request strobe, accepted when not busy (also in the done cycle)
//   reg_addr   in   register/control byte, captured on accept
//   reg_data   in   data byte, captured on accept
//   done       out  one-cycle pulse after STOP completes
//   busy       out  frame in progress
//   ack_error  out  sticky NACK flag, cleared on the next accept
//   scl        out  I2C clock
//   sda_oe     out  SDA pull-down enable
//   sda_in     in   sampled SDA line level
//
// Build option
//   I2C_NACK_ABORT_EN  when defined, a NACK ends the frame early: after the
//                      NACKed ACK slot the engine goes straight to STOP.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_reg_writer #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned CLK_DIV  = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_en,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       done,
  output logic       busy,
  output logic       ack_error,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [15:0] QTR_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;       // cycle counter within a quarter
  logic [1:0]  qtr_q, qtr_d;       // quarter index within the current phase
  logic [3:0]  bit_q, bit_d;       // 0..7 data bits, 8 = ACK slot
  logic [1:0]  byte_q, byte_d;     // byte index within the frame
  logic [23:0] shift_q, shift_d;   // MSB is the bit currently on the wire
  logic        ack_err_q, ack_err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        tick;
  logic        abort_now;

  // Line levels {scl, sda_oe} for the phase/quarter about to be entered.
  function automatic logic [1:0] line_levels(input state_e st, input logic [1:0] qtr,
                                             input logic ack_slot, input logic bit_val);
    logic [1:0] lv;
    case (st)
      ST_START: lv = {(qtr == 2'd0), 1'b1};
      ST_BIT:   lv = {((qtr == 2'd1) || (qtr == 2'd2)), (ack_slot ? 1'b0 : ~bit_val)};
      ST_STOP:  lv = {(qtr != 2'd0), (qtr != 2'd2)};
      default:  lv = 2'b10;
    endcase
    return lv;
  endfunction

  assign tick = (cnt_q == QTR_LAST);

`ifdef I2C_NACK_ABORT_EN
  // ack_error can only be set by the slot that is just finishing, because the
  // first NACK always ends the frame.
  assign abort_now = ack_err_q;
`else
  assign abort_now = 1'b0;
`endif

  // Next-state, counters, shift register and registered line levels.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        cnt_d  = 16'd0;
        qtr_d  = 2'd0;
        bit_d  = 4'd0;
        byte_d = 2'd0;
        if (write_en) begin
          state_d   = ST_START;
          shift_d   = {DEV_ADDR, 1'b0, reg_addr, reg_data};
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_START: begin
        cnt_d = tick ? 16'd0 : (cnt_q + 16'd1);
        if (tick) begin
          if (qtr_q == 2'd1) begin
            state_d = ST_BIT;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end

      ST_BIT: begin
        cnt_d = tick ? 16'd0 : (cnt_q + 16'd1);
        if (tick) begin
          qtr_d = qtr_q + 2'd1;  // wraps 3 -> 0 into the next slot
          // ACK is sampled on the last cycle of the second high quarter.
          if ((qtr_q == 2'd2) && (bit_q == 4'd8) && sda_in) begin
            ack_err_d = 1'b1;
          end else begin
            ack_err_d = ack_err_q;
          end
          if (qtr_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d  = 4'd0;
              byte_d = byte_q + 2'd1;
              if ((byte_q == 2'd2) || abort_now) begin
                state_d = ST_STOP;
              end else begin
                state_d = ST_BIT;
              end
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {shift_q[22:0], 1'b0};
            end
          end else begin
            bit_d = bit_q;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end

      ST_STOP: begin
        cnt_d = tick ? 16'd0 : (cnt_q + 16'd1);
        if (tick) begin
          if (qtr_q == 2'd2) begin
            state_d = ST_FIN;
            qtr_d   = 2'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end else begin
          qtr_d = qtr_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        qtr_d   = 2'd0;
        busy_d  = 1'b0;
      end
    endcase

    // Outputs follow the next state so they are registered yet aligned to
    // the quarter boundaries.
    {scl_d, sda_oe_d} = line_levels(state_d, qtr_d, (bit_d == 4'd8), shift_d[23]);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 4'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign ack_error = ack_err_q;
  assign scl       = scl_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_writer
// Directed bench for i2c_reg_writer with CLK_DIV=2. A small open-drain slave
// model ACKs (or NACKs the address byte on request) and a bus monitor decodes
// the bytes between START and STOP. Expected values are hand-computed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_reg_writer;

  localparam int CLK_DIV  = 2;
  localparam int FULL_LAT = 227;      // 113 quarters * 2 + 1
`ifdef I2C_NACK_ABORT_EN
  localparam int NACK_LAT   = 83;     // 41 quarters * 2 + 1
  localparam int NACK_BYTES = 1;
`else
  localparam int NACK_LAT   = 227;
  localparam int NACK_BYTES = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       write_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       done;
  logic       busy;
  logic       ack_error;
  logic       scl;
  logic       sda_oe;
  logic       sda_in;
  logic       sda_line;

  logic       slave_pull = 1'b0;
  logic       nack_addr  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  i2c_reg_writer #(
    .DEV_ADDR (7'h3C),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .done      (done),
    .busy      (busy),
    .ack_error (ack_error),
    .scl       (scl),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  assign sda_line = ~(sda_oe | slave_pull);
  assign sda_in   = sda_line;

  always #5 clk = ~clk;

  // Bus monitor and slave model, evaluated on the falling clk edge.
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic       in_frame = 1'b0;
  int         bit_cnt  = 0;
  int         byte_idx = 0;
  logic [7:0] sh       = 8'd0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (reset) begin
      in_frame   = 1'b0;
      bit_cnt    = 0;
      byte_idx   = 0;
      slave_pull = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (scl_prev && scl && sda_prev && !sda_line) begin
        in_frame = 1'b1;
        bit_cnt  = 0;
        byte_idx = 0;
      end else if (scl_prev && scl && !sda_prev && sda_line) begin
        in_frame = 1'b0;
      end else if (in_frame && !scl_prev && scl) begin
        if (bit_cnt < 8) begin
          sh = {sh[6:0], sda_line};
          bit_cnt++;
          if (bit_cnt == 8) rx_q.push_back(sh);
        end else begin
          bit_cnt = 0;
          byte_idx++;
        end
      end else if (in_frame && scl_prev && !scl) begin
        slave_pull = (bit_cnt == 8) && !(nack_addr && (byte_idx == 0));
      end
    end
    scl_prev = scl;
    sda_prev = sda_line;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0]  ev[3];
    logic [31:0] got;
    ev = '{e0, e1, e2};
    check_eq({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_byte%0d", tag, i), got, {24'd0, ev[i]});
    end
  endtask

  // Presents a request for one cycle; returns one step into the cycle after accept.
  task automatic do_accept(input logic [7:0] a, input logic [7:0] d);
    write_en = 1'b1;
    reg_addr = a;
    reg_data = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    reg_addr = ~a;
    reg_data = ~d;
  endtask

  // Counts cycles from the accept cycle until done; optional extra request at poke_at.
  task automatic wait_done(input int poke_at, output int lat);
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke_at != 0 && lat == poke_at) begin
        write_en = 1'b1;
        reg_addr = 8'h22;
        reg_data = 8'h55;
      end else begin
        write_en = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    reset    = 1'b1;
    write_en = 1'b0;
    reg_addr = 8'd0;
    reg_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_scl", scl, 1);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack_error", ack_error, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Normal write with a dropped request while busy
    rx_q.delete();
    base = done_cnt;
    do_accept(8'h00, 8'hAF);
    check_eq("normal_busy", busy, 1);
    wait_done(10, lat);
    check_eq("normal_latency", lat, FULL_LAT);
    check_eq("normal_busy_at_done", busy, 0);
    check_eq("normal_ack_error", ack_error, 0);
    repeat (300) @(posedge clk);
    #1;
    check_eq("drop_done_pulses", done_cnt - base, 1);
    check_eq("drop_busy_idle", busy, 0);
    check_bytes("normal", 3, 8'h78, 8'h00, 8'hAF);

    // Back-to-back: new request in the done cycle
    rx_q.delete();
    do_accept(8'h01, 8'h02);
    wait_done(0, lat);
    check_eq("b2b_first_latency", lat, FULL_LAT);
    check_eq("b2b_first_done", done, 1);
    rx_q.delete();
    do_accept(8'h40, 8'hFF);
    check_eq("b2b_busy", busy, 1);
    wait_done(0, lat);
    check_eq("b2b_latency", lat, FULL_LAT);
    check_bytes("b2b", 3, 8'h78, 8'h40, 8'hFF);

    // Address NACK
    repeat (5) @(posedge clk);
    #1;
    nack_addr = 1'b1;
    rx_q.delete();
    do_accept(8'h00, 8'hAF);
    wait_done(0, lat);
    check_eq("nack_latency", lat, NACK_LAT);
    check_eq("nack_ack_error", ack_error, 1);
    nack_addr = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("nack_sticky", ack_error, 1);
    check_bytes("nack", NACK_BYTES, 8'h78, 8'h00, 8'hAF);

    // Reset mid-frame, inside the register-address byte
    rx_q.delete();
    base = done_cnt;
    do_accept(8'h40, 8'h5A);
    check_eq("accept_clears_ack", ack_error, 0);
    repeat (117) @(posedge clk);
    #1;
    check_eq("mid_scl", scl, 0);
    check_eq("mid_sda_oe", sda_oe, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_scl", scl, 1);
    check_eq("abort_sda_oe", sda_oe, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ack_error", ack_error, 0);
    repeat (300) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt - base, 0);
    rx_q.delete();
    do_accept(8'h12, 8'h34);
    wait_done(0, lat);
    check_eq("after_abort_latency", lat, FULL_LAT);
    check_eq("after_abort_ack_error", ack_error, 0);
    check_bytes("after_abort", 3, 8'h78, 8'h12, 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
